// File: rtl/matmul_stream_if.sv
// Row-beat stream bundle for matmul_stream: A/B rows in, C rows out, plus status.
// The master side is the loader/sink; the slave side is the multiplier.
interface matmul_stream_if #(
  parameter int N  = 2,
  parameter int DW = 8
);
  localparam int AW = 2*DW + $clog2(N);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_data;
  logic [RW-1:0]   out_row;
  logic            out_last;
  logic            busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last, busy
  );
endinterface

// File: rtl/matmul_stream.sv
// Streaming N x N matrix multiply with one sequential MAC; A then B rows in, C rows out.
// Define MATMUL_SIGNED_EN for two's-complement elements (default: unsigned).
//
// state     | meaning
// S_LOAD    | accepting 2N row beats (A rows, then B rows)
// S_COMPUTE | N^3 MAC cycles, k innermost, C[i][j] written at k==N-1
// S_OUTPUT  | presenting C rows one per handshake
module matmul_stream #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rst,
  matmul_stream_if.slave s_bus
);
  localparam int AW = 2*DW + $clog2(N);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST = RW'(N-1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t r_state, w_state_nx;

  logic          r_in_ready, r_out_valid, r_busy;
  logic [RW-1:0] r_ld_row;
  logic          r_ld_b;
  logic [RW-1:0] r_i, r_j, r_k;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_acc;

  logic [DW-1:0] r_a [N][N];
  logic [DW-1:0] r_b [N][N];
  logic [AW-1:0] r_c [N][N];

  logic          w_in_fire, w_out_fire;
  logic          w_load_done, w_comp_done, w_out_done;
  logic [DW-1:0] w_a_el, w_b_el;
  logic [2*DW-1:0] w_prod;
  logic [AW-1:0] w_prod_ext, w_sum;
  logic [N*AW-1:0] w_out_data;

  assign w_in_fire   = s_bus.in_valid && r_in_ready;
  assign w_out_fire  = r_out_valid && s_bus.out_ready;
  assign w_load_done = w_in_fire && r_ld_b && (r_ld_row == LAST);
  assign w_comp_done = (r_state == S_COMPUTE) && (r_i == LAST) && (r_j == LAST) && (r_k == LAST);
  assign w_out_done  = w_out_fire && (r_row == LAST);

  assign w_a_el = r_a[r_i][r_k];
  assign w_b_el = r_b[r_k][r_j];

`ifdef MATMUL_SIGNED_EN
  assign w_prod     = $signed({{DW{w_a_el[DW-1]}}, w_a_el}) * $signed({{DW{w_b_el[DW-1]}}, w_b_el});
  assign w_prod_ext = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
`else
  assign w_prod     = {{DW{1'b0}}, w_a_el} * {{DW{1'b0}}, w_b_el};
  assign w_prod_ext = {{(AW-2*DW){1'b0}}, w_prod};
`endif

  assign w_sum = ((r_k == '0) ? '0 : r_acc) + w_prod_ext;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_LOAD:    if (w_load_done) w_state_nx = S_COMPUTE;
      S_COMPUTE: if (w_comp_done) w_state_nx = S_OUTPUT;
      S_OUTPUT:  if (w_out_done)  w_state_nx = S_LOAD;
      default:   w_state_nx = S_LOAD;
    endcase
  end

  // Handshake/status flags follow the next state so none of them is combinational on inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_LOAD;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ld_row    <= '0;
      r_ld_b      <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_row       <= '0;
      r_acc       <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx == S_LOAD);
      r_out_valid <= (w_state_nx == S_OUTPUT);
      r_busy      <= (w_state_nx != S_LOAD);

      if (w_in_fire) begin
        if (r_ld_row == LAST) begin
          r_ld_row <= '0;
          r_ld_b   <= ~r_ld_b;
        end else begin
          r_ld_row <= r_ld_row + 1'b1;
        end
      end

      if (r_state == S_COMPUTE) begin
        r_acc <= w_sum;
        if (r_k == LAST) begin
          r_k <= '0;
          if (r_j == LAST) begin
            r_j <= '0;
            r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end else begin
          r_k <= r_k + 1'b1;
        end
      end

      if (w_out_fire) r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
    end
  end

  // Matrix stores are never cleared; every job overwrites all entries.
  always_ff @(posedge clk) begin
    if (rst && w_in_fire) begin
      for (int c = 0; c < N; c++) begin
        if (!r_ld_b) r_a[r_ld_row][c] <= s_bus.in_data[(N-1-c)*DW +: DW];
        else         r_b[r_ld_row][c] <= s_bus.in_data[(N-1-c)*DW +: DW];
      end
    end
    if (rst && (r_state == S_COMPUTE) && (r_k == LAST)) r_c[r_i][r_j] <= w_sum;
  end

  always_comb begin
    w_out_data = '0;
    if (r_out_valid) begin
      for (int c = 0; c < N; c++) w_out_data[(N-1-c)*AW +: AW] = r_c[r_row][c];
    end
  end

  assign s_bus.in_ready  = r_in_ready;
  assign s_bus.out_valid = r_out_valid;
  assign s_bus.out_data  = w_out_data;
  assign s_bus.out_row   = r_out_valid ? r_row : '0;
  assign s_bus.out_last  = r_out_valid && (r_row == LAST);
  assign s_bus.busy      = r_busy;
endmodule

// File: tb/tb_matmul_stream.sv
// Directed bench for matmul_stream at N=2, DW=8: vector table plus backpressure,
// mid-compute reset and ignored-input sequences.
module tb_matmul_stream;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 2*DW + $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matmul_stream_if #(.N(N), .DW(DW)) bus ();

  matmul_stream #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus.slave)
  );

  typedef struct {
    string             name;
    logic [N*N*DW-1:0] a;
    logic [N*N*DW-1:0] b;
    logic [N*N*AW-1:0] c;
  } vec_t;

  vec_t vecs[5];
  int total = 0;
  int bad   = 0;

  localparam logic [N*N*DW-1:0] A_BASIC = {8'd1, 8'd2, 8'd4, 8'd8};
  localparam logic [N*N*DW-1:0] B_BASIC = {8'd1, 8'd3, 8'd5, 8'd11};
  localparam logic [N*N*AW-1:0] C_BASIC = {17'd11, 17'd25, 17'd44, 17'd100};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic load_job(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b);
    int w;
    for (int beat = 0; beat < 2*N; beat++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (beat < N) ? a[(N-1-beat)*N*DW +: N*DW] : b[(2*N-1-beat)*N*DW +: N*DW];
      w = 0;
      while (!bus.in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!bus.in_ready) check("load_ready_timeout", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_out(input string name);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(N*N*N));
  endtask

  task automatic recv_rows(input string name, input logic [N*N*AW-1:0] c);
    bus.out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, "_row"},   64'(bus.out_row),   64'(r));
      check({name, "_last"},  64'(bus.out_last),  64'(r == N-1));
      check({name, "_data"},  64'(bus.out_data),  64'(c[(N-1-r)*N*AW +: N*AW]));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    check({name, "_done_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_done_ready"}, 64'(bus.in_ready),  64'd1);
    check({name, "_done_busy"},  64'(bus.busy),      64'd0);
  endtask

  initial begin
    vecs[0] = '{"basic", A_BASIC, B_BASIC, C_BASIC};
`ifdef MATMUL_SIGNED_EN
    vecs[1] = '{"maxval", {4{8'hFF}}, {4{8'hFF}}, {4{17'd2}}};
`else
    vecs[1] = '{"maxval", {4{8'hFF}}, {4{8'hFF}}, {4{17'h1FC02}}};
`endif
    vecs[2] = '{"ident", {8'd1, 8'd0, 8'd0, 8'd1}, {8'd7, 8'd9, 8'd100, 8'd3},
                {17'd7, 17'd9, 17'd100, 17'd3}};
    vecs[3] = '{"mixed", {8'd2, 8'd3, 8'd5, 8'd7}, {8'd11, 8'd13, 8'd17, 8'd19},
                {17'd73, 17'd83, 17'd174, 17'd198}};
    vecs[4] = '{"zeroA", {4{8'd0}}, {8'd9, 8'd8, 8'd7, 8'd6}, {4{17'd0}}};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_row",   64'(bus.out_row),   64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int v = 0; v < 5; v++) begin
      load_job(vecs[v].a, vecs[v].b);
      check({vecs[v].name, "_ready_drop"}, 64'(bus.in_ready), 64'd0);
      check({vecs[v].name, "_busy"},       64'(bus.busy),     64'd1);
      wait_out(vecs[v].name);
      recv_rows(vecs[v].name, vecs[v].c);
    end

    // Backpressure: first row must hold while the sink stalls.
    load_job(A_BASIC, B_BASIC);
    wait_out("bp");
    for (int s = 0; s < 5; s++) begin
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_row",   64'(bus.out_row),   64'd0);
      check("bp_hold_data",  64'(bus.out_data),  64'(C_BASIC[(N-1)*N*AW +: N*AW]));
      check("bp_hold_ready", 64'(bus.in_ready),  64'd0);
      @(posedge clk); #1;
    end
    recv_rows("bp", C_BASIC);

    // Reset at the fourth compute cycle discards the job.
    load_job({4{8'd50}}, {4{8'd60}});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready_low", 64'(bus.in_ready),  64'd0);
    check("midrst_busy_low",     64'(bus.busy),      64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(bus.in_ready),  64'd1);
    check("midrst_busy",     64'(bus.busy),      64'd0);
    check("midrst_valid",    64'(bus.out_valid), 64'd0);
    load_job(A_BASIC, B_BASIC);
    wait_out("midrst");
    recv_rows("midrst", C_BASIC);

    // Garbage beats during COMPUTE/OUTPUT must not be taken.
    load_job(A_BASIC, B_BASIC);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    wait_out("ign");
    recv_rows("ign", C_BASIC);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    load_job(vecs[3].a, vecs[3].b);
    wait_out("ign_next");
    recv_rows("ign_next", vecs[3].c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/matmul_stream.md
# matmul_stream

Parametrised, handshaked successor to the fixed 2x2 multiplier. It accepts an N x N matrix A and an N x N matrix B as row beats on a valid/ready stream and computes C = A x B with a single sequential multiply-accumulate unit. It returns C one row per beat on a second valid/ready stream. It sits between the row loader and the result sink, and it replaces the one-shot load pulse and done flag with backpressure-capable handshakes.

## Interface
- N, 2, matrix dimension (N >= 2)
- DW, 8, element width in bits
- AW (localparam), 2*DW + $clog2(N), result element width; no overflow is possible
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  input row beat valid
- in_ready  out  1  block can accept a row
- in_data  in  N*DW  one row; column 0 in the MSBs
- out_valid  out  1  result row valid
- out_ready  in  1  sink accepts the result row
- out_data  out  N*AW  one row of C; column 0 in the MSBs
- out_row  out  max(1,$clog2(N))  index of the row on out_data
- out_last  out  1  high with row N-1
- busy  out  1  high in COMPUTE and OUTPUT

## Operation
- FSM states: LOAD -> COMPUTE -> OUTPUT -> LOAD.
- **LOAD**
  - in_ready=1.
  - Beats are stored in order: beats 0..N-1 are rows 0..N-1 of A, then beats N..2N-1 are rows 0..N-1 of B.
  - Acceptance of beat 2N-1 moves the FSM to COMPUTE.
- **COMPUTE**
  - in_ready=0; in_valid is ignored.
  - Nested counters i (row), j (column), k (inner) run with k innermost.
  - Each cycle: acc <= (k==0 ? 0 : acc) + A[i][k]*B[k][j].
  - On k==N-1, C[i][j] is written with the completed sum.
  - After i=j=k=N-1, the FSM moves to OUTPUT.
- **OUTPUT**
  - out_valid=1; out_data = C[r]; out_row = r; out_last = (r==N-1).
  - A row advances only on out_valid && out_ready.
  - Acceptance of the row with out_last returns the FSM to LOAD.
- Arithmetic:
  - Products are DW x DW -> 2*DW.
  - Sums are carried at AW width.
  - Unsigned unless the signed option is compiled in (see Configuration).
- The A, B and C stores are not cleared between jobs. Each job fully overwrites them.
- **Reset** (rst==0 at a rising edge), from any state including mid-LOAD or mid-COMPUTE:
  - FSM returns to LOAD; all counters are zeroed; partial data is discarded.
  - in_ready=0 during reset, then 1 on the first cycle after rst is released.
  - out_valid=0, out_data=0, out_row=0, out_last=0, busy=0.
- If out_valid=1 and out_ready=0, out_data, out_row and out_last hold stable.

## Timing
- Input throughput: one row per cycle while in_valid=1.
- Compute phase: exactly N^3 cycles.
- Latency: if beat 2N-1 is accepted at edge t, COMPUTE occupies edges t+1..t+N^3 and out_valid rises after edge t+N^3.
  - N=2: 8 COMPUTE cycles, with out_valid visible in the 9th cycle after the last input beat.
- Output throughput: with out_ready held at 1, N rows in N consecutive cycles.
- in_ready falls in the cycle after the last input beat is accepted. It rises in the cycle after the out_last row is accepted.
- busy equals (state != LOAD), registered.
- There is no combinational path from in_valid to in_ready or from out_ready to out_valid.

## Configuration
- Macro: MATMUL_SIGNED_EN.
- **Defined**
  - Elements are two's complement.
  - Multiply is $signed and is sign-extended to AW.
  - out_data elements are signed AW.
- **Undefined**
  - Elements are unsigned and zero-extended.
  - Identical bit patterns give unsigned results.

## Test plan
- **Basic, N=2, DW=8:** rows A={1,2},{4,8}, B={1,3},{5,11}, out_ready=1 -> row0 {11,25}, row1 {44,100}, out_last on row1; out_valid 9 cycles after the last beat.
- **Maximum values, unsigned:** all elements 255 -> every C element 130050 (0x1FC02), no truncation in 17 bits.
- **Backpressure:** out_ready=0 for 5 cycles after out_valid, then 1 -> row0 held stable for all 5 cycles; both rows then delivered in order. in_ready stays 0 until out_last is accepted, then returns to 1.
- **Reset mid-COMPUTE:** assert rst=0 at compute cycle 4 for one cycle -> the next cycle shows in_ready=1, busy=0, out_valid=0; a fresh basic job then gives {11,25},{44,100}.
- **Ignored input:** in_valid held at 1 with garbage data during COMPUTE and OUTPUT -> results unaffected; nothing is accepted until LOAD.
- **Signed, MATMUL_SIGNED_EN, N=3:** A=-I (0xFF on the diagonal), B={1,2,3},{4,5,6},{7,8,9} -> C={-1,-2,-3},{-4,-5,-6},{-7,-8,-9} sign-extended to AW=18; N^3=27 compute cycles.
